// File: rtl/display_scheduler.sv
// Frame scheduler for the serial display shift register: two buffered requesters,
// fixed-priority arbitration, start pulse, completion/timeout tracking and periodic refresh.
module display_scheduler #(
  parameter int unsigned WIDTH          = 48,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             time_valid_i,
  input  logic [WIDTH-1:0] time_data_i,
  input  logic             diag_valid_i,
  input  logic [WIDTH-1:0] diag_data_i,
  input  logic             sr_latch_i,
  output logic             sr_start_o,
  output logic [WIDTH-1:0] sr_data_o,
  output logic             busy_o,
  output logic             src_o,
  output logic             err_o,
  output logic [7:0]       frames_o
);

  localparam int unsigned REF_MAX = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;
  localparam int unsigned RW      = (REF_MAX > 0) ? $clog2(REF_MAX + 1) : 1;
  localparam int unsigned TMO_MAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned TW      = (TMO_MAX > 0) ? $clog2(TMO_MAX + 1) : 1;
  localparam bit          REF_EN  = (REFRESH_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_CLR, S_WAIT_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_buf_t, r_buf_d, r_sr_data;
  logic             r_pend_t, r_pend_d, r_has_frame;
  logic             r_sr_start, r_busy, r_src, r_err;
  logic [7:0]       r_frames;
  logic [RW-1:0]    r_ref_cnt, w_ref_cnt_nxt;
  logic [TW-1:0]    r_tmo_cnt, w_tmo_cnt_nxt;
  logic             w_load_t, w_load_d, w_done, w_abort;

  // Next-state, arbitration and counter control
  always_comb begin
    w_state_nxt   = r_state;
    w_ref_cnt_nxt = r_ref_cnt;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_load_t      = 1'b0;
    w_load_d      = 1'b0;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_ref_cnt != RW'(REF_MAX)) w_ref_cnt_nxt = r_ref_cnt + RW'(1);
        if (r_pend_t) begin
          w_load_t    = 1'b1;
          w_state_nxt = S_START;
        end else if (r_pend_d) begin
          w_load_d    = 1'b1;
          w_state_nxt = S_START;
        end else if (REF_EN && r_has_frame && (r_ref_cnt == RW'(REF_MAX))) begin
          w_state_nxt = S_START;
        end
      end
      S_START: w_state_nxt = S_WAIT_CLR;
      // A shifter that never drops its latch is treated as stalled as well
      S_WAIT_CLR: begin
        w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        if (r_tmo_cnt == TW'(TMO_MAX)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!sr_latch_i) begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        if (sr_latch_i) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tmo_cnt == TW'(TMO_MAX)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_START) begin
      w_ref_cnt_nxt = '0;
      w_tmo_cnt_nxt = '0;
    end
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_buf_t     <= '0;
      r_buf_d     <= '0;
      r_pend_t    <= 1'b0;
      r_pend_d    <= 1'b0;
      r_has_frame <= 1'b0;
      r_ref_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_sr_data   <= '0;
      r_sr_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_src       <= 1'b0;
      r_err       <= 1'b0;
      r_frames    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ref_cnt  <= w_ref_cnt_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_sr_start <= (w_state_nxt == S_START);
      r_busy     <= (w_state_nxt != S_IDLE);
      // A fresh pulse wins over the clear from a same-cycle load
      if (time_valid_i) begin
        r_buf_t  <= time_data_i;
        r_pend_t <= 1'b1;
      end else if (w_load_t) begin
        r_pend_t <= 1'b0;
      end
      if (diag_valid_i) begin
        r_buf_d  <= diag_data_i;
        r_pend_d <= 1'b1;
      end else if (w_load_d) begin
        r_pend_d <= 1'b0;
      end
      if (w_load_t) begin
        r_sr_data <= r_buf_t;
        r_src     <= 1'b0;
      end else if (w_load_d) begin
        r_sr_data <= r_buf_d;
        r_src     <= 1'b1;
      end
      if (w_done) begin
        r_frames    <= r_frames + 8'd1;
        r_has_frame <= 1'b1;
      end
      if (w_abort) r_err <= 1'b1;
    end
  end

  assign sr_start_o = r_sr_start;
  assign sr_data_o  = r_sr_data;
  assign busy_o     = r_busy;
  assign src_o      = r_src;
  assign err_o      = r_err;
  assign frames_o   = r_frames;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: two instances (refresh 50 and refresh off) checked each
// cycle against a transaction-level model, plus directed hand-computed checks.
module tb_display_scheduler;

  localparam int unsigned W     = 48;
  localparam int unsigned TMO   = 255;
  localparam int unsigned REF_A = 50;
  localparam int unsigned REF_B = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tv = 1'b0, dv = 1'b0;
  logic [W-1:0] td = '0, dd = '0;
  logic         stall = 1'b0;
  logic         run_cmp = 1'b0;

  logic         lat [2];
  int           rem [2];
  logic         st  [2];
  logic [W-1:0] dat [2];
  logic         bz  [2];
  logic         sr  [2];
  logic         er  [2];
  logic [7:0]   fr  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  display_scheduler #(.WIDTH(W), .REFRESH_CYCLES(REF_A), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk_i(clk), .rst_i(rst), .time_valid_i(tv), .time_data_i(td),
    .diag_valid_i(dv), .diag_data_i(dd), .sr_latch_i(lat[0]), .sr_start_o(st[0]),
    .sr_data_o(dat[0]), .busy_o(bz[0]), .src_o(sr[0]), .err_o(er[0]), .frames_o(fr[0]));

  display_scheduler #(.WIDTH(W), .REFRESH_CYCLES(REF_B), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk_i(clk), .rst_i(rst), .time_valid_i(tv), .time_data_i(td),
    .diag_valid_i(dv), .diag_data_i(dd), .sr_latch_i(lat[1]), .sr_start_o(st[1]),
    .sr_data_o(dat[1]), .busy_o(bz[1]), .src_o(sr[1]), .err_o(er[1]), .frames_o(fr[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Shift register stand-in: latch drops after a start and returns 2*W cycles later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        lat[k] <= 1'b1;
        rem[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (st[k]) begin
          lat[k] <= 1'b0;
          rem[k] <= stall ? 1000 : 2 * W;
        end else if (rem[k] != 0) begin
          rem[k] <= rem[k] - 1;
          if (rem[k] == 1) lat[k] <= 1'b1;
        end
      end
    end
  end

  // Transaction-level model: a frame in flight is tracked by its age since the start cycle
  bit           m_pt [2], m_pd [2], m_has [2], m_fly [2], m_low [2];
  bit           m_start [2], m_src [2], m_err [2];
  logic [W-1:0] m_bt [2], m_bd [2], m_data [2];
  logic [7:0]   m_frames [2];
  int unsigned  m_age [2], m_idle [2];

  function automatic int unsigned ref_of(input int k);
    return (k == 0) ? REF_A : REF_B;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pt[k] = 0; m_pd[k] = 0; m_has[k] = 0; m_fly[k] = 0; m_low[k] = 0;
      m_start[k] = 0; m_src[k] = 0; m_err[k] = 0;
      m_bt[k] = '0; m_bd[k] = '0; m_data[k] = '0; m_frames[k] = '0;
      m_age[k] = 0; m_idle[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit ld_t, ld_d, launch;
    int unsigned rc;
    ld_t = 0; ld_d = 0; launch = 0;
    rc = ref_of(k);
    if (!m_fly[k]) begin
      if (m_pt[k]) begin
        ld_t = 1; m_data[k] = m_bt[k]; m_src[k] = 0;
      end else if (m_pd[k]) begin
        ld_d = 1; m_data[k] = m_bd[k]; m_src[k] = 1;
      end
      launch = ld_t || ld_d || (rc != 0 && m_has[k] && m_idle[k] == rc - 1);
      if (launch) begin
        m_fly[k] = 1; m_age[k] = 0; m_low[k] = 0; m_idle[k] = 0;
      end else if (rc != 0 && m_idle[k] < rc - 1) begin
        m_idle[k]++;
      end
    end else if (m_age[k] == 0) begin
      m_age[k] = 1;
    end else if (m_low[k] && lat[k]) begin
      m_fly[k] = 0; m_has[k] = 1; m_frames[k] = m_frames[k] + 8'd1;
    end else if (m_age[k] == TMO) begin
      m_fly[k] = 0; m_err[k] = 1;
    end else begin
      if (!lat[k]) m_low[k] = 1;
      m_age[k]++;
    end
    if (ld_t) m_pt[k] = 0;
    if (ld_d) m_pd[k] = 0;
    if (tv) begin m_pt[k] = 1; m_bt[k] = td; end
    if (dv) begin m_pd[k] = 1; m_bd[k] = dd; end
    m_start[k] = launch;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        p = (k == 0) ? "a_" : "b_";
        chk({p, "start"},  64'(st[k]),  64'(m_start[k]));
        chk({p, "data"},   64'(dat[k]), 64'(m_data[k]));
        chk({p, "busy"},   64'(bz[k]),  64'(m_fly[k]));
        chk({p, "src"},    64'(sr[k]),  64'(m_src[k]));
        chk({p, "err"},    64'(er[k]),  64'(m_err[k]));
        chk({p, "frames"}, 64'(fr[k]),  64'(m_frames[k]));
      end
    end
  end

  task automatic pulse(input bit t, input bit d, input logic [W-1:0] tdv, input logic [W-1:0] ddv);
    @(negedge clk);
    tv = t; td = tdv; dv = d; dd = ddv;
    @(negedge clk);
    tv = 1'b0; dv = 1'b0;
  endtask

  task automatic wait_start_b(output logic [W-1:0] d, output bit s);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (st[1]) begin ok = 1; break; end
    end
    chk("b_start_seen", 64'(ok), 64'd1);
    d = dat[1];
    s = sr[1];
  endtask

  task automatic wait_idle_b();
    logic [W-1:0] held;
    int changes;
    bit ok;
    held = dat[1]; changes = 0; ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bz[1]) begin ok = 1; break; end
      if (dat[1] !== held) changes++;
    end
    chk("b_idle_reached", 64'(ok), 64'd1);
    chk("b_data_stable", 64'(changes), 64'd0);
  endtask

  task automatic quiet_b(input string nm, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (st[1]) n++;
    end
    chk(nm, 64'(n), 64'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    bit s;
    int n;

    repeat (3) @(negedge clk);
    run_cmp = 1'b1;
    chk("rst_start", 64'(st[1]), 64'd0);
    chk("rst_data", 64'(dat[1]), 64'd0);
    chk("rst_busy", 64'(bz[1]), 64'd0);
    chk("rst_err", 64'(er[1]), 64'd0);
    chk("rst_frames", 64'(fr[1]), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single time frame: start two cycles after the pulse, one cycle wide
    pulse(1, 0, 48'h0123_4567_89AB, '0);
    chk("t1_start_early", 64'(st[1]), 64'd0);
    @(negedge clk);
    chk("t1_start", 64'(st[1]), 64'd1);
    chk("t1_data", 64'(dat[1]), 64'h0123_4567_89AB);
    chk("t1_src", 64'(sr[1]), 64'd0);
    @(negedge clk);
    chk("t1_start_width", 64'(st[1]), 64'd0);
    wait_idle_b();
    chk("t1_frames", 64'(fr[1]), 64'd1);
    chk("t1_busy", 64'(bz[1]), 64'd0);

    // Refresh: instance a re-sends after 50 idle cycles, instance b never does
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (st[0]) break;
      n++;
      @(negedge clk);
    end
    chk("ref_idle_cycles", 64'(n), 64'd50);
    chk("ref_data", 64'(dat[0]), 64'h0123_4567_89AB);
    chk("ref_src", 64'(sr[0]), 64'd0);
    quiet_b("noref_starts", 150);

    // Simultaneous requests: time first, diag next
    pulse(1, 1, 48'hAAAA_0000_1111, 48'hBBBB_2222_3333);
    wait_start_b(d, s);
    chk("t2_first_data", 64'(d), 64'hAAAA_0000_1111);
    chk("t2_first_src", 64'(s), 64'd0);
    wait_idle_b();
    wait_start_b(d, s);
    chk("t2_second_data", 64'(d), 64'hBBBB_2222_3333);
    chk("t2_second_src", 64'(s), 64'd1);
    wait_idle_b();
    chk("t2_frames", 64'(fr[1]), 64'd3);

    // Latest diag wins while a frame is in flight
    pulse(1, 0, 48'h1234_5678_9ABC, '0);
    wait_start_b(d, s);
    chk("t3_first_data", 64'(d), 64'h1234_5678_9ABC);
    repeat (10) @(negedge clk);
    pulse(0, 1, '0, 48'hC0C0_C0C0_C0C0);
    repeat (20) @(negedge clk);
    pulse(0, 1, '0, 48'hD0D0_D0D0_D0D0);
    wait_idle_b();
    wait_start_b(d, s);
    chk("t3_second_data", 64'(d), 64'hD0D0_D0D0_D0D0);
    chk("t3_second_src", 64'(s), 64'd1);
    wait_idle_b();
    quiet_b("t3_no_extra", 150);
    chk("t3_frames", 64'(fr[1]), 64'd5);

    // Stalled shifter: timeout, error flag, then the pending frame still goes out
    stall = 1'b1;
    pulse(1, 0, 48'hEEEE_EEEE_EEEE, '0);
    wait_start_b(d, s);
    pulse(0, 1, '0, 48'hF00F_F00F_F00F);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (er[1]) begin n = 1; break; end
    end
    chk("t4_err_seen", 64'(n), 64'd1);
    chk("t4_frames_held", 64'(fr[1]), 64'd5);
    chk("t4_busy", 64'(bz[1]), 64'd0);
    stall = 1'b0;
    wait_start_b(d, s);
    chk("t4_next_data", 64'(d), 64'hF00F_F00F_F00F);
    chk("t4_next_src", 64'(s), 64'd1);
    wait_idle_b();
    chk("t4_frames", 64'(fr[1]), 64'd6);
    chk("t4_err_sticky", 64'(er[1]), 64'd1);

    // Asynchronous reset mid-frame with a diag frame pending
    pulse(1, 0, 48'h6666_7777_8888, '0);
    wait_start_b(d, s);
    repeat (10) @(negedge clk);
    pulse(0, 1, '0, 48'h9999_AAAA_BBBB);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_start", 64'(st[1]), 64'd0);
    chk("ar_data", 64'(dat[1]), 64'd0);
    chk("ar_busy", 64'(bz[1]), 64'd0);
    chk("ar_src", 64'(sr[1]), 64'd0);
    chk("ar_err", 64'(er[1]), 64'd0);
    chk("ar_frames", 64'(fr[1]), 64'd0);
    chk("ar_a_busy", 64'(bz[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet_b("ar_pending_dropped", 150);
    chk("ar_frames_after", 64'(fr[1]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Sequences the serial display shift register: accepts frames from two requesters (decoded time and diagnostic pattern), arbitrates with fixed priority, holds the selected frame stable on the shift register's parallel input, and issues one start pulse per frame. It detects completion from the shift register's latch output, re-sends the last frame periodically, and flags a stalled shifter. It sits between the MSF decoder/diagnostic logic and the shift register driving the external display.

## Interface

- WIDTH, 48: frame width in bits; must match the shift register.
- REFRESH_CYCLES, 1000000: idle cycles before the last frame is re-sent; 0 disables refresh.
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT_DONE before abort; must be > 2*WIDTH+2.

Ports:

- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- time_valid_i  in  1  one-cycle pulse; time_data_i is valid.
- time_data_i  in  WIDTH  time frame.
- diag_valid_i  in  1  one-cycle pulse; diag_data_i is valid.
- diag_data_i  in  WIDTH  diagnostic frame.
- sr_latch_i  in  1  latch output of the shift register; 1 means idle/done.
- sr_start_o  out  1  start pulse to the shift register.
- sr_data_o  out  WIDTH  parallel frame to the shift register; registered.
- busy_o  out  1  a frame is in flight (state != IDLE).
- src_o  out  1  source of the frame on sr_data_o: 0 = time, 1 = diag.
- err_o  out  1  sticky timeout flag; cleared only by reset.
- frames_o  out  8  count of completed frames; wraps 255 -> 0.

## Operation

- Per source: a WIDTH-bit buffer and a pending flag. A valid pulse captures data into the buffer and sets pending. A valid pulse while pending overwrites the buffer (latest wins).
- FSM states: IDLE, START, WAIT_CLR, WAIT_DONE.
- IDLE:
  - If time pending, load the time buffer into sr_data_o, set src_o=0, clear time pending, and go to START.
  - Otherwise, if diag pending, do the same for diag with src_o=1.
  - Otherwise, if refresh is enabled, has_frame=1, and the refresh counter equals REFRESH_CYCLES-1, go to START with sr_data_o and src_o unchanged.
- START: sr_start_o=1 for exactly this cycle. Next state is WAIT_CLR.
- WAIT_CLR: go to WAIT_DONE when sr_latch_i==0.
- WAIT_DONE:
  - When sr_latch_i==1: increment frames_o, set has_frame, go to IDLE.
  - When the timeout counter reaches TIMEOUT_CYCLES-1: set err_o, go to IDLE, do not increment frames_o.
- The timeout counter runs in both WAIT_CLR and WAIT_DONE. It clears on entry to START.
- sr_data_o changes only on the IDLE->START transition. It is stable from START until the return to IDLE.
- Refresh counter:
  - Increments only in IDLE.
  - Clears on every transition to START.
  - Saturates at REFRESH_CYCLES-1.
- Simultaneous valid pulses: both are captured. Time is served first, and diag is served after that frame completes.
- A valid pulse on the same cycle its source is being loaded from the buffer: the new data is captured and pending remains set, so a second frame follows.
- A valid pulse arriving while a frame is in flight is only buffered. sr_data_o is never disturbed.

## Timing

- Reset values:
  - Outputs: sr_start_o=0, sr_data_o=0, busy_o=0, src_o=0, err_o=0, frames_o=0.
  - Internal: both pending flags 0, has_frame=0, state IDLE, all counters 0.
- Reset mid-frame: immediate return to IDLE. The shift register is reset by the same reset.
- Latency from a valid pulse (edge n) to sr_start_o=1:
  - Pending is set at edge n+1.
  - START is entered at edge n+2, so sr_start_o is high during cycle n+2.
- Frame duration: the shift register needs 2*WIDTH cycles plus 2 cycles for latch, so START to return-to-IDLE is about 2*WIDTH+3 cycles (99 for WIDTH=48).
- Back-to-back frames: there is 1 IDLE cycle between WAIT_DONE exit and the next START.

## Test plan

- Reset, then time_valid_i with 48'h0123_4567_89AB -> sr_start_o is a single-cycle pulse 2 cycles later; sr_data_o=48'h012345_6789AB, src_o=0; after completion frames_o=1 and busy_o=0.
- time_valid_i and diag_valid_i in the same cycle (A, B) -> frame A is sent first with src_o=0, then B with src_o=1; frames_o=2; sr_data_o never changes while busy_o=1.
- diag_valid_i C while frame A is in flight, then D before A completes -> only D is sent after A; C is never shifted.
- REFRESH_CYCLES=50 with no new valid after a frame -> sr_start_o re-pulses 50 idle cycles later with identical sr_data_o; with REFRESH_CYCLES=0 there is no re-send.
- Hold sr_latch_i at 0 after start (stalled shifter) -> err_o=1 after TIMEOUT_CYCLES, state returns to IDLE, frames_o is unchanged, and the next pending frame is still issued.
- Assert rst_i asynchronously mid-WAIT_DONE with diag pending -> all outputs go to reset values immediately with no clock edge required, and the pending frame is discarded.
